// File: rtl/ysyx_24100005_wbu_pkg.sv
// Shared types and constants for the NPC writeback unit.
package ysyx_24100005_wbu_pkg;

  // Default widths of the writeback datapath. The holding-slot struct is sized
  // from these, so the top-level ADDR_WIDTH/DATA_WIDTH must stay equal to them.
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  // Number of back-to-back LSU grants tolerated while the EXU slot waits.
  localparam logic [1:0] STREAK_MAX = 2'd2;

  // Which holding slot owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_EXU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

  // One buffered result waiting for the register-file write port.
  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_slot_t;

endpackage

// File: rtl/ysyx_24100005_wb_slot.sv
// Single-entry holding slot for one result source. Accepts a result on a
// valid/ready handshake, silently drops writes to x0, and empties when the
// arbiter grants it the register-file port.
module ysyx_24100005_wb_slot
  import ysyx_24100005_wbu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WB_ADDR_W-1:0] in_rd,
  input  logic [WB_DATA_W-1:0] in_data,
  input  logic                 grant,
  output wb_slot_t             slot
);

  // Ready does not look at in_valid: a granted slot frees up on this edge,
  // so it can take a new result on the same edge it drains.
  assign in_ready = !slot.valid || grant;

  // Fill on handshake (x0 results complete the handshake but stay empty),
  // otherwise drain when granted.
  // NOTE: sequential state is assigned with <= so every flop samples the
  //       pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot <= '0;
    end else if (in_valid && in_ready) begin
      slot.valid <= (in_rd != '0);
      slot.rd    <= in_rd;
      slot.data  <= in_data;
    end else if (grant) begin
      slot.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_24100005_wbu.sv
// Writeback unit: buffers one EXU and one LSU result, arbitrates a single
// register-file write per cycle (LSU first, with an EXU starvation guard),
// and keeps the per-register busy scoreboard used by the IDU for RAW stalls.
module ysyx_24100005_wbu
  import ysyx_24100005_wbu_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  input  logic                     exu_valid,
  output logic                     exu_ready,
  input  logic [ADDR_WIDTH-1:0]    exu_rd,
  input  logic [DATA_WIDTH-1:0]    exu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic [2**ADDR_WIDTH-1:0] busy
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  wb_slot_t   exu_slot;
  wb_slot_t   lsu_slot;
  wb_src_e    grant_src;
  logic       grant_exu;
  logic       grant_lsu;
  logic [1:0] lsu_streak;
  logic [NUM_REGS-1:0] busy_next;

  ysyx_24100005_wb_slot u_exu_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (exu_valid),
    .in_ready (exu_ready),
    .in_rd    (exu_rd),
    .in_data  (exu_data),
    .grant    (grant_exu),
    .slot     (exu_slot)
  );

  ysyx_24100005_wb_slot u_lsu_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (lsu_valid),
    .in_ready (lsu_ready),
    .in_rd    (lsu_rd),
    .in_data  (lsu_data),
    .grant    (grant_lsu),
    .slot     (lsu_slot)
  );

  // Pick the write source: LSU wins unless the EXU has already waited
  // STREAK_MAX LSU grants, in which case the EXU goes next.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    //       leaves it unassigned and a latch is never inferred.
    grant_src = WB_NONE;
    if (exu_slot.valid && (!lsu_slot.valid || lsu_streak == STREAK_MAX)) begin
      grant_src = WB_EXU;
    end else if (lsu_slot.valid) begin
      grant_src = WB_LSU;
    end
  end

  assign grant_exu = (grant_src == WB_EXU);
  assign grant_lsu = (grant_src == WB_LSU);

  // Drive the register-file port from the granted slot; zero when idle.
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (grant_src)
      WB_EXU: begin
        rf_wen   = 1'b1;
        rf_waddr = exu_slot.rd;
        rf_wdata = exu_slot.data;
      end
      WB_LSU: begin
        rf_wen   = 1'b1;
        rf_waddr = lsu_slot.rd;
        rf_wdata = lsu_slot.data;
      end
      default: ;
    endcase
  end

  // Count LSU grants that happen while the EXU slot is waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsu_streak <= '0;
    end else if (!exu_slot.valid || grant_exu) begin
      lsu_streak <= '0;
    end else if (grant_lsu) begin
      lsu_streak <= lsu_streak + 2'd1;
    end
  end

  // Scoreboard next state: clear on writeback, then set on issue so a
  // same-index set overrides the clear; x0 is never busy.
  always_comb begin
    busy_next = busy;
    if (rf_wen) begin
      busy_next[rf_waddr] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register; reset clears every pending-write flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule
